// File: rtl/uart_in_mux_burst.sv
// uart_in_mux_burst: round-robin UART RX -> USB TX multiplexer with burst framing.
// Each channel is visited in turn. A visited channel that is enabled and non-empty
// gives up to MAX_BURST bytes into a local buffer. The block then writes one header
// byte {count-1, index} to the shared TX FIFO, followed by the buffered bytes.
module uart_in_mux_burst #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned UART_COUNT = 4,
  parameter int unsigned INDEX_BITS = 2,
  parameter int unsigned MAX_BURST  = 8,
  parameter int unsigned COUNT_BITS = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [UART_COUNT-1:0]            channel_enable,
  input  logic                             fifo_full,
  output logic                             fifo_write,
  output logic [DATA_BITS-1:0]             fifo_data,
  output logic [UART_COUNT-1:0]            read,
  input  logic [UART_COUNT-1:0]            empty,
  input  logic [UART_COUNT*DATA_BITS-1:0]  data,
  output logic                             busy
);

  // count must hold MAX_BURST itself, so it is one bit wider than the header field
  localparam int unsigned CNT_W     = COUNT_BITS + 1;
  localparam int unsigned BUF_DEPTH = 1 << COUNT_BITS;
  localparam int unsigned HDR_W     = COUNT_BITS + INDEX_BITS;

  typedef enum logic [2:0] {
    S_SCAN        = 3'd0,
    S_GATHER      = 3'd1,
    S_GATHER_WAIT = 3'd2,
    S_SEND_HEADER = 3'd3,
    S_SEND_DATA   = 3'd4
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;

  logic [INDEX_BITS-1:0]   r_index;
  logic [CNT_W-1:0]        r_count;
  logic [COUNT_BITS-1:0]   r_ptr;
  logic [DATA_BITS-1:0]    r_buf [BUF_DEPTH];

  logic                    r_fifo_write;
  logic [DATA_BITS-1:0]    r_fifo_data;
  logic [UART_COUNT-1:0]   r_read;
  logic                    r_busy;

  logic [INDEX_BITS-1:0]   w_index_nxt;
  logic [CNT_W-1:0]        w_count_nxt;
  logic [COUNT_BITS-1:0]   w_ptr_nxt;
  logic                    w_fifo_write_nxt;
  logic [DATA_BITS-1:0]    w_fifo_data_nxt;
  logic [UART_COUNT-1:0]   w_read_nxt;
  logic                    w_busy_nxt;
  logic                    w_buf_we;

  logic                    w_sel_en;
  logic                    w_sel_empty;
  logic [DATA_BITS-1:0]    w_sel_data;
  logic                    w_take;
  logic                    w_room;
  logic                    w_gather_ok;
  logic [COUNT_BITS-1:0]   w_count_m1;
  logic                    w_last;
  logic [INDEX_BITS-1:0]   w_index_inc;
  logic [HDR_W-1:0]        w_header;

  // Selected-channel view and shared decision terms
  always_comb begin
    w_sel_en    = channel_enable[r_index];
    w_sel_empty = empty[r_index];
    w_sel_data  = data[32'(r_index) * DATA_BITS +: DATA_BITS];
    w_take      = w_sel_en && !w_sel_empty;
    w_room      = (r_count < CNT_W'(MAX_BURST));
    w_gather_ok = !w_sel_empty && w_room;
    w_count_m1  = COUNT_BITS'(r_count - CNT_W'(1));
    w_last      = (r_ptr == w_count_m1);
    w_header    = {w_count_m1, r_index};
    if (r_index == INDEX_BITS'(UART_COUNT - 1)) begin
      w_index_inc = '0;
    end else begin
      w_index_inc = r_index + INDEX_BITS'(1);
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_SCAN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_SCAN: begin
        if (w_take) begin
          w_state_nxt = S_GATHER;
        end
      end
      S_GATHER: begin
        if (w_gather_ok) begin
          w_state_nxt = S_GATHER_WAIT;
        end else begin
          w_state_nxt = S_SEND_HEADER;
        end
      end
      S_GATHER_WAIT: begin
        w_state_nxt = S_GATHER;
      end
      S_SEND_HEADER: begin
        if (!fifo_full) begin
          w_state_nxt = S_SEND_DATA;
        end
      end
      S_SEND_DATA: begin
        if (!fifo_full && w_last) begin
          w_state_nxt = S_SCAN;
        end
      end
      default: begin
        w_state_nxt = S_SCAN;
      end
    endcase
  end

  // Output and datapath next values; strobes default low, data fields hold
  always_comb begin
    w_index_nxt      = r_index;
    w_count_nxt      = r_count;
    w_ptr_nxt        = r_ptr;
    w_fifo_write_nxt = 1'b0;
    w_fifo_data_nxt  = r_fifo_data;
    w_read_nxt       = '0;
    w_buf_we         = 1'b0;
    w_busy_nxt       = (w_state_nxt != S_SCAN);
    unique case (r_state)
      S_SCAN: begin
        if (w_take) begin
          w_count_nxt = '0;
        end else begin
          w_index_nxt = w_index_inc;
        end
      end
      S_GATHER: begin
        if (w_gather_ok) begin
          w_buf_we    = 1'b1;
          w_count_nxt = r_count + CNT_W'(1);
          w_read_nxt  = UART_COUNT'(1) << r_index;
        end
      end
      S_GATHER_WAIT: begin
      end
      S_SEND_HEADER: begin
        if (!fifo_full) begin
          w_fifo_write_nxt = 1'b1;
          w_fifo_data_nxt  = DATA_BITS'(w_header);
          w_ptr_nxt        = '0;
        end
      end
      S_SEND_DATA: begin
        if (!fifo_full) begin
          w_fifo_write_nxt = 1'b1;
          w_fifo_data_nxt  = r_buf[r_ptr];
          w_ptr_nxt        = r_ptr + COUNT_BITS'(1);
          // Next scan starts after the channel just served
          if (w_last) begin
            w_index_nxt = w_index_inc;
          end
        end
      end
      default: begin
      end
    endcase
  end

  // Registered outputs and control datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_index      <= '0;
      r_count      <= '0;
      r_ptr        <= '0;
      r_fifo_write <= 1'b0;
      r_fifo_data  <= '0;
      r_read       <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_index      <= w_index_nxt;
      r_count      <= w_count_nxt;
      r_ptr        <= w_ptr_nxt;
      r_fifo_write <= w_fifo_write_nxt;
      r_fifo_data  <= w_fifo_data_nxt;
      r_read       <= w_read_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  // Burst buffer; contents after reset are irrelevant, so it has no reset
  always_ff @(posedge clk) begin
    if (w_buf_we) begin
      r_buf[r_count[COUNT_BITS-1:0]] <= w_sel_data;
    end
  end

  assign fifo_write = r_fifo_write;
  assign fifo_data  = r_fifo_data;
  assign read       = r_read;
  assign busy       = r_busy;

endmodule

// File: tb/tb_uart_in_mux_burst.sv
// Bench for uart_in_mux_burst: queue-based RX FIFOs, a burst-level stream model,
// and a per-cycle compare of the TX write stream plus read-strobe sanity.
module tb_uart_in_mux_burst;

  localparam int unsigned DW = 8;
  localparam int unsigned UC = 4;
  localparam int unsigned IB = 2;
  localparam int unsigned MB = 8;
  localparam int unsigned CB = 3;

  logic               clk;
  logic               reset;
  logic [UC-1:0]      channel_enable;
  logic               fifo_full;
  logic               fifo_write;
  logic [DW-1:0]      fifo_data;
  logic [UC-1:0]      read;
  logic [UC-1:0]      empty;
  logic [UC*DW-1:0]   data;
  logic               busy;

  logic [7:0]         uq [UC][$];
  logic [7:0]         exp_q [$];
  int                 wcyc [$];
  int                 rd_cnt [UC];
  int                 n_checks;
  int                 n_err;
  int                 n_wr;
  int                 cyc;
  logic [UC-1:0]      last_read;

  uart_in_mux_burst #(
    .DATA_BITS(DW), .UART_COUNT(UC), .INDEX_BITS(IB), .MAX_BURST(MB), .COUNT_BITS(CB)
  ) dut (
    .clk(clk), .reset(reset), .channel_enable(channel_enable), .fifo_full(fifo_full),
    .fifo_write(fifo_write), .fifo_data(fifo_data), .read(read), .empty(empty),
    .data(data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Drive the RX FIFO heads from the channel queues
  task automatic refresh();
    for (int i = 0; i < UC; i++) begin
      empty[i] = (uq[i].size() == 0);
      data[i*DW +: DW] = (uq[i].size() == 0) ? 8'h00 : uq[i][0];
    end
  endtask

  // Expected TX stream from queue contents: visit channels round-robin from start,
  // each enabled non-empty channel yields header {n-1, idx} then n bytes, n <= MB.
  function automatic void build(input int start);
    int sz [UC];
    int pos [UC];
    int idx;
    int left;
    int n;
    idx = start;
    left = 0;
    for (int i = 0; i < UC; i++) begin
      sz[i] = uq[i].size();
      pos[i] = 0;
      if (channel_enable[i]) left += sz[i];
    end
    while (left > 0) begin
      if (channel_enable[idx] && sz[idx] > pos[idx]) begin
        n = sz[idx] - pos[idx];
        if (n > MB) n = MB;
        exp_q.push_back(8'(((n - 1) << IB) | idx));
        for (int k = 0; k < n; k++) exp_q.push_back(uq[idx][pos[idx] + k]);
        pos[idx] += n;
        left -= n;
      end
      idx = (idx + 1) % UC;
    end
  endfunction

  // One clock: check outputs after the rising edge, then emulate FIFO pops at the falling edge
  task automatic tick();
    logic          full_e;
    logic [UC-1:0] empty_e;
    logic [7:0]    want;
    @(posedge clk);
    full_e = fifo_full;
    empty_e = empty;
    #1;
    cyc++;
    if (reset) begin
      if (read != '0) begin
        chk("read_onehot", 32'($countones(read)), 32'd1);
        chk("read_of_empty", 32'(read & empty_e), 32'd0);
      end
      if (fifo_write) begin
        n_wr++;
        wcyc.push_back(cyc);
        chk("write_while_full", 32'(full_e), 32'd0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_write: got 0x%0h expected no write", fifo_data);
        end else begin
          want = exp_q.pop_front();
          chk("stream", 32'(fifo_data), 32'(want));
        end
      end
    end
    last_read = read;
    @(negedge clk);
    for (int i = 0; i < UC; i++) begin
      if (last_read[i] && uq[i].size() > 0) begin
        void'(uq[i].pop_front());
        rd_cnt[i]++;
      end
    end
    refresh();
  endtask

  // Hold reset and clear all per-test state
  task automatic start_test(input logic [UC-1:0] en);
    reset = 1'b0;
    for (int i = 0; i < UC; i++) begin
      uq[i].delete();
      rd_cnt[i] = 0;
    end
    exp_q.delete();
    wcyc.delete();
    n_wr = 0;
    channel_enable = en;
    fifo_full = 1'b0;
    refresh();
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic drain(input string name, input int budget);
    for (int k = 0; k < budget; k++) begin
      tick();
      if (exp_q.size() == 0 && !busy) break;
    end
    chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    repeat (3) tick();
    chk({name, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int   found;
    int   w0;
    n_checks = 0;
    n_err = 0;
    n_wr = 0;
    cyc = 0;
    last_read = '0;
    reset = 1'b0;
    channel_enable = '0;
    fifo_full = 1'b0;
    empty = '1;
    data = '0;
    for (int i = 0; i < UC; i++) rd_cnt[i] = 0;
    #2;
    chk("reset_fifo_write", 32'(fifo_write), 32'd0);
    chk("reset_fifo_data", 32'(fifo_data), 32'd0);
    chk("reset_read", 32'(read), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    @(negedge clk);

    // Single byte on ch2
    start_test(4'b1111);
    uq[2].push_back(8'h41);
    refresh();
    build(0);
    chk("t1_model_len", 32'(exp_q.size()), 32'd2);
    chk("t1_model_hdr", 32'(exp_q[0]), 32'h02);
    release_reset();
    drain("t1", 60);
    chk("t1_read2_once", 32'(rd_cnt[2]), 32'd1);
    chk("t1_reads_total", 32'(rd_cnt[0] + rd_cnt[1] + rd_cnt[3]), 32'd0);
    chk("t1_writes", 32'(n_wr), 32'd2);

    // Burst cap and fairness on ch0 with 10 bytes
    start_test(4'b1111);
    for (int k = 0; k < 10; k++) uq[0].push_back(8'(8'h10 + k));
    refresh();
    build(0);
    chk("t2_model_len", 32'(exp_q.size()), 32'd12);
    chk("t2_model_hdr1", 32'(exp_q[0]), 32'h1C);
    chk("t2_model_hdr2", 32'(exp_q[9]), 32'h04);
    release_reset();
    drain("t2", 200);
    chk("t2_writes", 32'(n_wr), 32'd12);
    chk("t2_reads0", 32'(rd_cnt[0]), 32'd10);
    chk("t2_fair_gap", 32'(wcyc.size() >= 10 && (wcyc[9] - wcyc[8]) >= 10), 32'd1);

    // Round robin ch1 then ch3
    start_test(4'b1111);
    uq[1].push_back(8'hA1);
    uq[3].push_back(8'hA3);
    refresh();
    build(0);
    chk("t3_model_0", 32'(exp_q[0]), 32'h01);
    chk("t3_model_2", 32'(exp_q[2]), 32'h03);
    chk("t3_model_3", 32'(exp_q[3]), 32'hA3);
    release_reset();
    drain("t3", 100);
    chk("t3_no_read0", 32'(rd_cnt[0]), 32'd0);
    chk("t3_no_read2", 32'(rd_cnt[2]), 32'd0);
    chk("t3_read1", 32'(rd_cnt[1]), 32'd1);
    chk("t3_read3", 32'(rd_cnt[3]), 32'd1);

    // Enable mask holds ch1 off, then releases it
    start_test(4'b1101);
    uq[1].push_back(8'h55);
    uq[1].push_back(8'h66);
    refresh();
    build(0);
    chk("t4_model_masked", 32'(exp_q.size()), 32'd0);
    release_reset();
    repeat (20) tick();
    chk("t4_masked_writes", 32'(n_wr), 32'd0);
    chk("t4_masked_reads", 32'(rd_cnt[1]), 32'd0);
    chk("t4_masked_busy", 32'(busy), 32'd0);
    channel_enable = 4'b1111;
    build(0);
    chk("t4_model_hdr", 32'(exp_q[0]), 32'h05);
    found = 0;
    for (int k = 0; k < UC + 2; k++) begin
      tick();
      if (last_read[1]) begin
        found = 1;
        break;
      end
    end
    chk("t4_enable_latency", 32'(found), 32'd1);
    drain("t4", 100);
    chk("t4_writes", 32'(n_wr), 32'd3);

    // Backpressure during data phase of a 3-byte burst
    start_test(4'b1111);
    uq[0].push_back(8'h31);
    uq[0].push_back(8'h32);
    uq[0].push_back(8'h33);
    refresh();
    build(0);
    chk("t5_model_hdr", 32'(exp_q[0]), 32'h08);
    release_reset();
    for (int k = 0; k < 40; k++) begin
      tick();
      if (n_wr >= 1) break;
    end
    chk("t5_header_seen", 32'(n_wr), 32'd1);
    fifo_full = 1'b1;
    w0 = n_wr;
    repeat (5) tick();
    chk("t5_stall_no_write", 32'(n_wr - w0), 32'd0);
    fifo_full = 1'b0;
    drain("t5", 60);
    chk("t5_writes", 32'(n_wr), 32'd4);

    // Async reset in the middle of gathering from ch2
    start_test(4'b1111);
    for (int k = 0; k < 5; k++) uq[2].push_back(8'(8'h71 + k));
    refresh();
    build(0);
    release_reset();
    for (int k = 0; k < 40; k++) begin
      tick();
      if (rd_cnt[2] >= 2) break;
    end
    chk("t6_two_pops", 32'(rd_cnt[2]), 32'd2);
    chk("t6_no_writes_yet", 32'(n_wr), 32'd0);
    #3;
    reset = 1'b0;
    #1;
    chk("t6_async_read", 32'(read), 32'd0);
    chk("t6_async_busy", 32'(busy), 32'd0);
    chk("t6_async_write", 32'(fifo_write), 32'd0);
    chk("t6_async_data", 32'(fifo_data), 32'd0);
    uq[1].push_back(8'hB1);
    refresh();
    exp_q.delete();
    build(0);
    chk("t6_model_first", 32'(exp_q[0]), 32'h01);
    chk("t6_model_resume_hdr", 32'(exp_q[2]), 32'h0A);
    release_reset();
    drain("t6", 100);
    chk("t6_reads2", 32'(rd_cnt[2]), 32'd5);
    chk("t6_writes", 32'(n_wr), 32'd6);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
